vga_scan_timing: RTL and testbench



---
 rtl/vga_scan_timing_if.sv | 29 ++
 rtl/vga_scan_timing.sv | 127 ++++++++++++
 tb/tb_vga_scan_timing.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_timing_if.sv
// Pixel request bus between the VGA scan-timing stage and the image source.
// The timing stage (master) presents the coordinates of the current pixel
// period. The image source (slave) answers with that pixel's colour bits.
interface vga_scan_timing_if;
    logic [9:0] req_x;
    logic [9:0] req_y;
    logic       req_visible;
    logic       pixel_r;
    logic       pixel_g;
    logic       pixel_b;

    modport master (
        output req_x,
        output req_y,
        output req_visible,
        input  pixel_r,
        input  pixel_g,
        input  pixel_b
    );

    modport slave (
        input  req_x,
        input  req_y,
        input  req_visible,
        output pixel_r,
        output pixel_g,
        output pixel_b
    );
endinterface

// File: rtl/vga_scan_timing.sv
// VGA scan-timing and pixel-output stage.
// The stage divides the system clock down to the pixel rate. It runs the
// horizontal and vertical position counters and requests colour for the
// current position. One pixel period later it drives the registered sync
// and RGB pins.
module vga_scan_timing #(
    parameter int PIXEL_DIV       = 2,
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic              clock,
    input  logic              reset,
    vga_scan_timing_if.master pix,
    output logic              frame_start,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_r,
    output logic              vga_g,
    output logic              vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // The counters are 10 bits wide and the divider is 4 bits wide.
    // Reject any geometry that they cannot represent.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_scan_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIXEL_DIV < 1 || PIXEL_DIV > 16) begin : g_div_check
        $error("vga_scan_timing: PIXEL_DIV must be in 1..16");
    end

    // The window bounds can reach 1024, so they are 11 bits wide. The
    // counters are zero-extended to 11 bits before each compare.
    localparam logic [3:0]  DIV_LAST  = 4'(PIXEL_DIV - 1);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    // This is the pin level when sync is not asserted. XOR with it maps
    // "sync asserted" onto the chosen polarity.
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [3:0] div;
    logic [9:0] h;
    logic [9:0] v;
    logic       tick;
    logic       h_last;
    logic       v_last;
    logic       pixel_visible;
    logic       hsync_on;
    logic       vsync_on;

    // Decode the pixel tick, the wrap points and the sync windows from the
    // current counter values.
    always_comb begin
        tick          = (div == DIV_LAST);
        h_last        = (h == H_LAST);
        v_last        = (v == V_LAST);
        pixel_visible = ({1'b0, h} < H_VIS_END) && ({1'b0, v} < V_VIS_END);
        hsync_on      = ({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END);
        vsync_on      = ({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END);
    end

    assign pix.req_x       = h;
    assign pix.req_y       = v;
    assign pix.req_visible = pixel_visible;

    // Pixel-rate divider, position counters and the one-clock frame_start pulse.
    // NOTE: state registers use non-blocking assignments so every block reads
    // the pre-edge values; blocking here would race the output stage below.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            frame_start <= 1'b0;
        end else begin
            // NOTE: a default assignment before the conditional logic makes
            // the pulse self-clearing without an explicit else on every path.
            frame_start <= 1'b0;
            if (tick) begin
                div         <= '0;
                frame_start <= h_last && v_last;
                if (h_last) begin
                    h <= '0;
                    v <= v_last ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end else begin
                div <= div + 4'd1;
            end
        end
    end

    // On each tick, register sync and blanked RGB from the pre-increment
    // coordinates, so that all pins lag the request by one pixel period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_hsync <= SYNC_IDLE;
            vga_vsync <= SYNC_IDLE;
            vga_r     <= 1'b0;
            vga_g     <= 1'b0;
            vga_b     <= 1'b0;
        end else if (tick) begin
            vga_hsync <= hsync_on ^ SYNC_IDLE;
            vga_vsync <= vsync_on ^ SYNC_IDLE;
            vga_r     <= pixel_visible & pix.pixel_r;
            vga_g     <= pixel_visible & pix.pixel_g;
            vga_b     <= pixel_visible & pix.pixel_b;
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing.
// The bench uses two reduced-geometry instances so that whole frames fit in
// a short run:
//   dut_a: PIXEL_DIV=2, active-low sync. Line = 15 px, frame = 8 lines.
//          Hsync covers h 10..12 and vsync covers v 5..6.
//   dut_b: PIXEL_DIV=1, active-high sync, with the same geometry.
module tb_vga_scan_timing;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vga_scan_timing_if if_a ();
    vga_scan_timing_if if_b ();

    // Image sources: colour is a simple function of the request coordinates.
    assign if_a.pixel_r = if_a.req_x[0];
    assign if_a.pixel_g = 1'b1;
    assign if_a.pixel_b = 1'b0;
    assign if_b.pixel_r = 1'b1;
    assign if_b.pixel_g = if_b.req_x[0];
    assign if_b.pixel_b = 1'b1;

    logic fs_a, hs_a, vs_a, r_a, g_a, b_a;
    logic fs_b, hs_b, vs_b, r_b, g_b, b_b;

    vga_scan_timing #(
        .PIXEL_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE_LOW(1)
    ) dut_a (
        .clock(clock), .reset(reset), .pix(if_a),
        .frame_start(fs_a), .vga_hsync(hs_a), .vga_vsync(vs_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_scan_timing #(
        .PIXEL_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE_LOW(0)
    ) dut_b (
        .clock(clock), .reset(reset), .pix(if_b),
        .frame_start(fs_b), .vga_hsync(hs_b), .vga_vsync(vs_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One row is the expected dut_a state n rising edges after reset release.
    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       vis;
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
        logic       fs;
    } vec_t;

    function automatic vec_t mk(input int n, input int x, input int y,
                                input logic vis, input logic hs, input logic vs,
                                input logic [2:0] rgb, input logic fs);
        vec_t t;
        t.n = n; t.x = 10'(x); t.y = 10'(y); t.vis = vis;
        t.hs = hs; t.vs = vs; t.rgb = rgb; t.fs = fs;
        return t;
    endfunction

    function automatic logic [26:0] pack_a();
        return {if_a.req_x, if_a.req_y, if_a.req_visible, hs_a, vs_a,
                r_a, g_a, b_a, fs_a};
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[$];
        int   n;
        int   fs_count;
        bit   found;
        int   first_rise, second_rise, hs_line_cnt, r_line_cnt, g_line_cnt;
        int   fs_b_first, fs_b_second;
        logic hs_b_prev;

        // Columns: n, req_x, req_y, visible, hsync, vsync, rgb, frame_start.
        // The pins show the pixel requested one period (2 clocks) earlier.
        vecs.push_back(mk(  0,  0, 0, 1, 1, 1, 3'b000, 0));
        vecs.push_back(mk(  1,  0, 0, 1, 1, 1, 3'b000, 0));
        vecs.push_back(mk(  2,  1, 0, 1, 1, 1, 3'b010, 0));
        vecs.push_back(mk(  3,  1, 0, 1, 1, 1, 3'b010, 0));
        vecs.push_back(mk(  4,  2, 0, 1, 1, 1, 3'b110, 0));
        vecs.push_back(mk( 16,  8, 0, 0, 1, 1, 3'b110, 0));
        vecs.push_back(mk( 18,  9, 0, 0, 1, 1, 3'b000, 0));
        vecs.push_back(mk( 20, 10, 0, 0, 1, 1, 3'b000, 0));
        vecs.push_back(mk( 22, 11, 0, 0, 0, 1, 3'b000, 0));
        vecs.push_back(mk( 23, 11, 0, 0, 0, 1, 3'b000, 0));
        vecs.push_back(mk( 26, 13, 0, 0, 0, 1, 3'b000, 0));
        vecs.push_back(mk( 28, 14, 0, 0, 1, 1, 3'b000, 0));
        vecs.push_back(mk( 30,  0, 1, 1, 1, 1, 3'b000, 0));
        vecs.push_back(mk( 32,  1, 1, 1, 1, 1, 3'b010, 0));
        vecs.push_back(mk(120,  0, 4, 0, 1, 1, 3'b000, 0));
        vecs.push_back(mk(122,  1, 4, 0, 1, 1, 3'b000, 0));
        vecs.push_back(mk(152,  1, 5, 0, 1, 0, 3'b000, 0));
        vecs.push_back(mk(172, 11, 5, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(180,  0, 6, 0, 1, 0, 3'b000, 0));
        vecs.push_back(mk(210,  0, 7, 0, 1, 0, 3'b000, 0));
        vecs.push_back(mk(212,  1, 7, 0, 1, 1, 3'b000, 0));
        vecs.push_back(mk(238, 14, 7, 0, 1, 1, 3'b000, 0));
        vecs.push_back(mk(239, 14, 7, 0, 1, 1, 3'b000, 0));
        vecs.push_back(mk(240,  0, 0, 1, 1, 1, 3'b000, 1));
        vecs.push_back(mk(241,  0, 0, 1, 1, 1, 3'b000, 0));
        vecs.push_back(mk(242,  1, 0, 1, 1, 1, 3'b010, 0));

        // Hold reset over a few edges, then release it mid-low-phase.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n        = 0;
        fs_count = 0;

        foreach (vecs[i]) begin
            while (n < vecs[i].n) begin
                step();
                n++;
                if (fs_a) fs_count++;
            end
            check($sformatf("vec_n%0d {x,y,vis,hs,vs,rgb,fs}", vecs[i].n), 32'(pack_a()),
                  32'({vecs[i].x, vecs[i].y, vecs[i].vis, vecs[i].hs, vecs[i].vs,
                       vecs[i].rgb, vecs[i].fs}));
        end
        while (n < 250) begin
            step();
            n++;
            if (fs_a) fs_count++;
        end
        check("frame_start_pulses_in_250_clocks", 32'(fs_count), 32'd1);

        // Run into a point where both syncs are asserted, then assert reset
        // asynchronously between edges.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            if (hs_a == 1'b0 && vs_a == 1'b0) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_sync_low: got timeout after 300 clocks, expected hsync=vsync=0");
        end
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_a {x,y,hs,vs,rgb,fs}",
              32'({if_a.req_x, if_a.req_y, hs_a, vs_a, r_a, g_a, b_a, fs_a}),
              32'({10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0}));
        check("async_reset_b {x,y,hs,vs,rgb,fs}",
              32'({if_b.req_x, if_b.req_y, hs_b, vs_b, r_b, g_b, b_b, fs_b}),
              32'({10'd0, 10'd0, 1'b0, 1'b0, 3'b000, 1'b0}));
        step();
        check("reset_holds_x_a", 32'(if_a.req_x), 32'd0);

        // Release again. dut_a must need exactly two clocks before its first
        // tick. dut_b ticks on every clock.
        @(negedge clock);
        reset = 1'b0;
        #1;
        first_rise  = -1;
        second_rise = -1;
        hs_line_cnt = 0;
        r_line_cnt  = 0;
        g_line_cnt  = 0;
        fs_b_first  = -1;
        fs_b_second = -1;
        hs_b_prev   = hs_b;
        for (int m = 1; m <= 245; m++) begin
            step();
            if (m == 1) check("release_x_a_after_1_clock", 32'(if_a.req_x), 32'd0);
            if (m == 2) check("release_x_a_after_2_clocks", 32'(if_a.req_x), 32'd1);
            if (hs_b && !hs_b_prev) begin
                if (first_rise < 0) first_rise = m;
                else if (second_rise < 0) second_rise = m;
            end
            hs_b_prev = hs_b;
            if (m <= 15) begin
                if (hs_b) hs_line_cnt++;
                if (r_b)  r_line_cnt++;
                if (g_b)  g_line_cnt++;
            end
            if (fs_b) begin
                if (fs_b_first < 0) fs_b_first = m;
                else if (fs_b_second < 0) fs_b_second = m;
            end
        end
        check("div1_hsync_first_rise_clock", 32'(first_rise), 32'd11);
        check("div1_line_period_clocks", 32'(second_rise - first_rise), 32'd15);
        check("div1_hsync_high_clocks", 32'(hs_line_cnt), 32'd3);
        check("div1_red_visible_clocks", 32'(r_line_cnt), 32'd8);
        check("div1_green_odd_pixel_clocks", 32'(g_line_cnt), 32'd4);
        check("div1_first_frame_start_clock", 32'(fs_b_first), 32'd120);
        check("div1_frame_period_clocks", 32'(fs_b_second - fs_b_first), 32'd120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
